sseg_scan_mux: RTL

//   Parametrised N-digit multiplexed 7-segment driver for the Nexys2 display path.
//   - Single block replacing the separate clock-gen / digit-pointer / segment-mux / anode-control chain.
//   - Captures hex nibbles into a shadow buffer and commits them only at frame boundaries, so the display never tears.
//   - Scans the digits with a blanking gap between them to suppress ghosting.

---
 rtl/sseg_scan_mux.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/sseg_scan_mux.sv
// Multiplexed N-digit 7-segment scanner with frame-synchronous buffer commit.
// Optional leading-zero suppression when SSEG_LZ_SUPPRESS_EN is defined.
module sseg_scan_mux #(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned CLK_HZ     = 50000000,
   parameter int unsigned SCAN_HZ    = 10000,
   parameter int unsigned BLANK_CYC  = 64
) (
   input  logic                    clk_50MHz,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic                    load,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_mask,
   output logic [6:0]              sseg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   anode,
   output logic                    frame_done
);

   localparam int unsigned DIV     = CLK_HZ / SCAN_HZ;
   localparam int unsigned CNT_MAX = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
   localparam int unsigned CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
   localparam int unsigned PTR_W   = $clog2(NUM_DIGITS);
   localparam int unsigned DIG_W   = 4 * NUM_DIGITS;

   typedef enum logic {ST_DRIVE, ST_BLANK} state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [PTR_W-1:0]        ptr_q, ptr_d;
   logic [DIG_W-1:0]        pend_dig_q, pend_dig_d, disp_dig_q, disp_dig_d;
   logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
   logic [NUM_DIGITS-1:0]   pend_msk_q, pend_msk_d, disp_msk_q, disp_msk_d;
   logic [6:0]              sseg_q, sseg_d;
   logic                    dp_q, dp_d;
   logic [NUM_DIGITS-1:0]   anode_q, anode_d;
   logic                    frame_done_q, frame_done_d;
   logic                    adv_c, wrap_c;
   logic [3:0]              nib_c;
   logic [NUM_DIGITS-1:0]   lz_dark_c;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'b1000000;
         4'h1: hex7 = 7'b1111001;
         4'h2: hex7 = 7'b0100100;
         4'h3: hex7 = 7'b0110000;
         4'h4: hex7 = 7'b0011001;
         4'h5: hex7 = 7'b0010010;
         4'h6: hex7 = 7'b0000010;
         4'h7: hex7 = 7'b1111000;
         4'h8: hex7 = 7'b0000000;
         4'h9: hex7 = 7'b0010000;
         4'hA: hex7 = 7'b0001000;
         4'hB: hex7 = 7'b0000011;
         4'hC: hex7 = 7'b1000110;
         4'hD: hex7 = 7'b0100001;
         4'hE: hex7 = 7'b0000110;
         default: hex7 = 7'b0001110;
      endcase
   endfunction

   // Slot sequencer: DRIVE for DIV clocks, optional BLANK gap, then next digit.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      ptr_d   = ptr_q;
      adv_c   = 1'b0;
      case (state_q)
         ST_DRIVE: begin
            if (cnt_q == CNT_W'(DIV - 1)) begin
               cnt_d = '0;
               if (BLANK_CYC == 0) adv_c = 1'b1;
               else                state_d = ST_BLANK;
            end
         end
         ST_BLANK: begin
            if (cnt_q == CNT_W'(BLANK_CYC - 1)) begin
               cnt_d   = '0;
               adv_c   = 1'b1;
               state_d = ST_DRIVE;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_DRIVE;
         end
      endcase
      wrap_c = adv_c && (ptr_q == PTR_W'(NUM_DIGITS - 1));
      if (adv_c) ptr_d = wrap_c ? '0 : ptr_q + PTR_W'(1);
   end

   // A load on the commit clock bypasses straight into the display buffer.
   always_comb begin
      pend_dig_d = load ? digits_in  : pend_dig_q;
      pend_dp_d  = load ? dp_in      : pend_dp_q;
      pend_msk_d = load ? blank_mask : pend_msk_q;
      disp_dig_d = wrap_c ? pend_dig_d : disp_dig_q;
      disp_dp_d  = wrap_c ? pend_dp_d  : disp_dp_q;
      disp_msk_d = wrap_c ? pend_msk_d : disp_msk_q;
   end

`ifdef SSEG_LZ_SUPPRESS_EN
   // Digit k dark when it and every higher nibble are zero; digit 0 always shown.
   always_comb begin
      logic zero_above;
      zero_above = 1'b1;
      lz_dark_c  = '0;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         zero_above   = zero_above && (disp_dig_q[4*k +: 4] == 4'h0);
         lz_dark_c[k] = zero_above;
      end
   end
`else
   assign lz_dark_c = '0;
`endif

   always_comb begin
      nib_c = 4'h0;
      for (int k = 0; k < NUM_DIGITS; k++)
         if (ptr_q == PTR_W'(k)) nib_c = disp_dig_q[4*k +: 4];
   end

   // Output image of the current state, registered one clock later.
   always_comb begin
      anode_d      = '1;
      sseg_d       = 7'h7F;
      dp_d         = 1'b1;
      frame_done_d = wrap_c;
      if ((state_q == ST_DRIVE) && !disp_msk_q[ptr_q]) begin
         anode_d[ptr_q] = 1'b0;
         sseg_d         = lz_dark_c[ptr_q] ? 7'h7F : hex7(nib_c);
         dp_d           = ~disp_dp_q[ptr_q];
      end
   end

   always_ff @(posedge clk_50MHz or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_DRIVE;
         cnt_q        <= '0;
         ptr_q        <= '0;
         pend_dig_q   <= '0;
         pend_dp_q    <= '0;
         pend_msk_q   <= '0;
         disp_dig_q   <= '0;
         disp_dp_q    <= '0;
         disp_msk_q   <= '0;
         sseg_q       <= 7'h7F;
         dp_q         <= 1'b1;
         anode_q      <= '1;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         ptr_q        <= ptr_d;
         pend_dig_q   <= pend_dig_d;
         pend_dp_q    <= pend_dp_d;
         pend_msk_q   <= pend_msk_d;
         disp_dig_q   <= disp_dig_d;
         disp_dp_q    <= disp_dp_d;
         disp_msk_q   <= disp_msk_d;
         sseg_q       <= sseg_d;
         dp_q         <= dp_d;
         anode_q      <= anode_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign sseg       = sseg_q;
   assign dp         = dp_q;
   assign anode      = anode_q;
   assign frame_done = frame_done_q;

endmodule
